// File: rtl/rm_retire_buffer_if.sv
// Retirement-buffer port bundle: multi-channel retire inputs, single-entry head output, status.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface rm_retire_buffer_if #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int IRQW  = 32
) ();
  logic                         clear_i;
  logic [NRET-1:0]              in_valid;
  logic [NRET*64-1:0]           in_order;
  logic [NRET*XLEN-1:0]         in_pc;
  logic [NRET*32-1:0]           in_insn;
  logic [NRET-1:0]              in_trap;
  logic [NRET-1:0]              in_intr;
  logic [IRQW-1:0]              irq_i;
  logic                         out_valid;
  logic                         out_ready;
  logic [63:0]                  out_order;
  logic [XLEN-1:0]              out_pc;
  logic [31:0]                  out_insn;
  logic                         out_trap;
  logic                         out_intr;
  logic [IRQW-1:0]              out_irq;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  logic                         overflow_o;
  logic                         order_err_o;

  modport master (
    output clear_i, in_valid, in_order, in_pc, in_insn, in_trap, in_intr, irq_i, out_ready,
    input  out_valid, out_order, out_pc, out_insn, out_trap, out_intr, out_irq,
           count_o, overflow_o, order_err_o
  );

  modport slave (
    input  clear_i, in_valid, in_order, in_pc, in_insn, in_trap, in_intr, irq_i, out_ready,
    output out_valid, out_order, out_pc, out_insn, out_trap, out_intr, out_irq,
           count_o, overflow_o, order_err_o
  );
endinterface

// File: rtl/rm_retire_buffer.sv
// Retirement buffer: compacts up to NRET retirements per cycle into a circular buffer,
// releases one per cycle, tags entries with sampled irq lines and checks order continuity.
module rm_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int IRQW  = 32
) (
  input logic              clk,
  input logic              reset_n,
  rm_retire_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]     order_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     insn_mem  [DEPTH];
  logic            trap_mem  [DEPTH];
  logic            intr_mem  [DEPTH];
  logic [IRQW-1:0] irq_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          order_err_q, order_err_d;
  logic          first_seen_q, first_seen_d;
  logic [63:0]   exp_order_q, exp_order_d;

  logic [PW-1:0] slot_addr [NRET];
  logic          head_valid, pop, accept, order_bad, base_found;
  logic [63:0]   exp_base, last_order;
  int            n_valid, free_slots;

  assign head_valid = (count_q != '0);

  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so no latch is inferred.
    n_valid    = 0;
    order_bad  = 1'b0;
    base_found = 1'b0;
    exp_base   = exp_order_q;
    last_order = exp_order_q;
    for (int k = 0; k < NRET; k++) slot_addr[k] = '0;

    // Before the first accepted batch the expected order is taken from the batch itself.
    for (int k = 0; k < NRET; k++) begin
      if (bus.in_valid[k] && !base_found) begin
        base_found = 1'b1;
        if (!first_seen_q) exp_base = bus.in_order[64*k +: 64];
      end
    end

    // Compaction: channel k lands at wr_ptr + (number of valid channels below k).
    for (int k = 0; k < NRET; k++) begin
      slot_addr[k] = PW'((int'(wr_ptr_q) + n_valid) % DEPTH);
      if (bus.in_valid[k]) begin
        if (bus.in_order[64*k +: 64] != exp_base + 64'(n_valid)) order_bad = 1'b1;
        last_order = bus.in_order[64*k +: 64];
        n_valid    = n_valid + 1;
      end
    end

    pop        = head_valid && bus.out_ready;
    free_slots = DEPTH - int'(count_q) + (pop ? 1 : 0);
    accept     = !bus.clear_i && (n_valid != 0) && (n_valid <= free_slots);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    order_err_d  = order_err_q;
    first_seen_d = first_seen_q;
    exp_order_d  = exp_order_q;

    if (bus.clear_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      order_err_d  = 1'b0;
      first_seen_d = 1'b0;
      exp_order_d  = '0;
    end else begin
      if (pop) rd_ptr_d = PW'((int'(rd_ptr_q) + 1) % DEPTH);
      if (n_valid > free_slots) overflow_d = 1'b1;
      if (accept) begin
        wr_ptr_d     = PW'((int'(wr_ptr_q) + n_valid) % DEPTH);
        first_seen_d = 1'b1;
        exp_order_d  = last_order + 64'd1;
        if (order_bad) order_err_d = 1'b1;
      end
      count_d = CW'(int'(count_q) + (accept ? n_valid : 0) - (pop ? 1 : 0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
      first_seen_q <= 1'b0;
      exp_order_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      order_err_q  <= order_err_d;
      first_seen_q <= first_seen_d;
      exp_order_q  <= exp_order_d;
    end
  end

  // NOTE: storage is not reset; outputs are gated by head_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (accept && bus.in_valid[k]) begin
        order_mem[slot_addr[k]] <= bus.in_order[64*k +: 64];
        pc_mem[slot_addr[k]]    <= bus.in_pc[XLEN*k +: XLEN];
        insn_mem[slot_addr[k]]  <= bus.in_insn[32*k +: 32];
        trap_mem[slot_addr[k]]  <= bus.in_trap[k];
        intr_mem[slot_addr[k]]  <= bus.in_intr[k];
        irq_mem[slot_addr[k]]   <= bus.irq_i;
      end
    end
  end

  assign bus.out_valid   = head_valid;
  assign bus.out_order   = head_valid ? order_mem[rd_ptr_q] : '0;
  assign bus.out_pc      = head_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.out_insn    = head_valid ? insn_mem[rd_ptr_q]  : '0;
  assign bus.out_trap    = head_valid ? trap_mem[rd_ptr_q]  : 1'b0;
  assign bus.out_intr    = head_valid ? intr_mem[rd_ptr_q]  : 1'b0;
  assign bus.out_irq     = head_valid ? irq_mem[rd_ptr_q]   : '0;
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.order_err_o = order_err_q;
endmodule

// File: tb/tb_rm_retire_buffer.sv
// Bench for rm_retire_buffer: directed vector table, hand-written overflow/reset sequences,
// and random traffic checked every cycle against a queue-based reference model.
module tb_rm_retire_buffer;
  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int IRQW  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rm_retire_buffer_if #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH), .IRQW(IRQW)) bus ();

  rm_retire_buffer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH), .IRQW(IRQW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [31:0] irq;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf, m_err, m_first;
  logic [63:0] m_exp;

  typedef struct {
    logic        clr;
    logic [1:0]  v;
    logic [63:0] o0, o1;
    logic [31:0] pc0;
    logic        rdy;
    logic [31:0] irq;
    logic        e_valid;
    logic [63:0] e_order;
    logic [31:0] e_pc;
    logic [3:0]  e_count;
    logic        e_ovf, e_err;
    logic [31:0] e_irq;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [63:0] o, input logic [31:0] pc);
    return {o[15:0], pc[15:0]};
  endfunction

  task automatic drive(input logic clr, input logic [1:0] v, input logic [63:0] o0,
                       input logic [63:0] o1, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic rdy, input logic [31:0] irq);
    bus.clear_i   = clr;
    bus.in_valid  = v;
    bus.in_order  = {o1, o0};
    bus.in_pc     = {pc1, pc0};
    bus.in_insn   = {insn_of(o1, pc1), insn_of(o0, pc0)};
    bus.in_trap   = {o1[1], o0[1]};
    bus.in_intr   = {o1[2], o0[2]};
    bus.out_ready = rdy;
    bus.irq_i     = irq;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_err = 0; m_first = 0; m_exp = '0;
  endtask

  // One clock of the spec's behaviour on a FIFO queue, using the inputs currently driven.
  task automatic model_step();
    ent_t        b[$];
    ent_t        e;
    bit          pop;
    int          free;
    logic [63:0] base;
    if (bus.clear_i) begin
      model_reset();
      return;
    end
    pop = (mq.size() > 0) && bus.out_ready;
    for (int k = 0; k < NRET; k++) begin
      if (bus.in_valid[k]) begin
        e.order = bus.in_order[64*k +: 64];
        e.pc    = bus.in_pc[32*k +: 32];
        e.insn  = bus.in_insn[32*k +: 32];
        e.trap  = bus.in_trap[k];
        e.intr  = bus.in_intr[k];
        e.irq   = bus.irq_i;
        b.push_back(e);
      end
    end
    free = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    if (b.size() > free) m_ovf = 1;
    else if (b.size() > 0) begin
      base = m_first ? m_exp : b[0].order;
      for (int j = 0; j < b.size(); j++) begin
        if (b[j].order != base + 64'(j)) m_err = 1;
        mq.push_back(b[j]);
      end
      m_first = 1;
      m_exp   = b[b.size()-1].order + 64'd1;
    end
  endtask

  task automatic compare_model(input string tag);
    ent_t h;
    h = '{order: '0, pc: '0, insn: '0, trap: 1'b0, intr: 1'b0, irq: '0};
    if (mq.size() > 0) h = mq[0];
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
    check({tag, ".order"}, bus.out_order, h.order);
    check({tag, ".pc"},    64'(bus.out_pc), 64'(h.pc));
    check({tag, ".insn"},  64'(bus.out_insn), 64'(h.insn));
    check({tag, ".trap"},  64'(bus.out_trap), 64'(h.trap));
    check({tag, ".intr"},  64'(bus.out_intr), 64'(h.intr));
    check({tag, ".irq"},   64'(bus.out_irq), 64'(h.irq));
    check({tag, ".count"}, 64'(bus.count_o), 64'(mq.size()));
    check({tag, ".ovf"},   64'(bus.overflow_o), 64'(m_ovf));
    check({tag, ".err"},   64'(bus.order_err_o), 64'(m_err));
  endtask

  // Inputs already driven; advance one clock and compare against the model.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic apply(input string tag, input logic clr, input logic [1:0] v,
                       input logic [63:0] o0, input logic [63:0] o1, input logic rdy);
    drive(clr, v, o0, o1, 32'h1000 + 32'(o0) * 4, 32'h1004 + 32'(o0) * 4, rdy, 32'h0);
    cycle(tag);
  endtask

  initial begin
    //          clr v      o0     o1     pc0     rdy irq     | valid order pc      cnt ovf err irq
    tbl[0]  = '{0, 2'b01, 64'd5,  64'd0,  32'h80,  0, 32'h0,   1, 64'd5,  32'h80,  4'd1, 0, 0, 32'h0};
    tbl[1]  = '{0, 2'b00, 64'd0,  64'd0,  32'h0,   1, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};
    tbl[2]  = '{1, 2'b00, 64'd0,  64'd0,  32'h0,   0, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};
    tbl[3]  = '{0, 2'b11, 64'd10, 64'd11, 32'h100, 1, 32'h0,   1, 64'd10, 32'h100, 4'd2, 0, 0, 32'h0};
    tbl[4]  = '{0, 2'b10, 64'd99, 64'd12, 32'h104, 1, 32'h0,   1, 64'd11, 32'h104, 4'd2, 0, 0, 32'h0};
    tbl[5]  = '{0, 2'b00, 64'd0,  64'd0,  32'h0,   1, 32'h0,   1, 64'd12, 32'h108, 4'd1, 0, 0, 32'h0};
    tbl[6]  = '{0, 2'b00, 64'd0,  64'd0,  32'h0,   1, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};
    tbl[7]  = '{0, 2'b01, 64'd13, 64'd0,  32'h200, 0, 32'h800, 1, 64'd13, 32'h200, 4'd1, 0, 0, 32'h800};
    tbl[8]  = '{0, 2'b01, 64'd14, 64'd0,  32'h204, 0, 32'h0,   1, 64'd13, 32'h200, 4'd2, 0, 0, 32'h800};
    tbl[9]  = '{0, 2'b00, 64'd0,  64'd0,  32'h0,   1, 32'h0,   1, 64'd14, 32'h204, 4'd1, 0, 0, 32'h0};
    tbl[10] = '{0, 2'b00, 64'd0,  64'd0,  32'h0,   1, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};
    tbl[11] = '{1, 2'b00, 64'd0,  64'd0,  32'h0,   0, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};
    tbl[12] = '{0, 2'b01, 64'd20, 64'd0,  32'h300, 0, 32'h0,   1, 64'd20, 32'h300, 4'd1, 0, 0, 32'h0};
    tbl[13] = '{0, 2'b01, 64'd22, 64'd0,  32'h304, 0, 32'h0,   1, 64'd20, 32'h300, 4'd2, 0, 1, 32'h0};
    tbl[14] = '{0, 2'b01, 64'd23, 64'd0,  32'h308, 0, 32'h0,   1, 64'd20, 32'h300, 4'd3, 0, 1, 32'h0};
    tbl[15] = '{1, 2'b11, 64'd30, 64'd31, 32'h400, 0, 32'h0,   0, 64'd0,  32'h0,   4'd0, 0, 0, 32'h0};

    drive(0, 2'b00, 64'd0, 64'd0, 32'h0, 32'h0, 0, 32'h0);
    model_reset();
    #12;
    check("reset.valid", 64'(bus.out_valid), 64'd0);
    check("reset.count", 64'(bus.count_o), 64'd0);
    check("reset.order", bus.out_order, 64'd0);
    check("reset.flags", 64'({bus.overflow_o, bus.order_err_o}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: spec-derived expectations plus the model cross-check.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].clr, tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].pc0, tbl[i].pc0 + 32'd4,
            tbl[i].rdy, tbl[i].irq);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.valid", i), 64'(bus.out_valid), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d.order", i), bus.out_order, tbl[i].e_order);
      check($sformatf("vec%0d.pc", i), 64'(bus.out_pc), 64'(tbl[i].e_pc));
      check($sformatf("vec%0d.count", i), 64'(bus.count_o), 64'(tbl[i].e_count));
      check($sformatf("vec%0d.ovf", i), 64'(bus.overflow_o), 64'(tbl[i].e_ovf));
      check($sformatf("vec%0d.err", i), 64'(bus.order_err_o), 64'(tbl[i].e_err));
      check($sformatf("vec%0d.irq", i), 64'(bus.out_irq), 64'(tbl[i].e_irq));
    end

    // Fill to DEPTH, then overflow with and without a same-cycle pop.
    apply("fill.clr", 1, 2'b00, 64'd0, 64'd0, 0);
    for (int i = 0; i < 4; i++) apply("fill", 0, 2'b11, 64'(2*i), 64'(2*i+1), 0);
    check("full.count", 64'(bus.count_o), 64'd8);
    apply("ovf.n2", 0, 2'b11, 64'd8, 64'd9, 0);
    check("ovf.flag", 64'(bus.overflow_o), 64'd1);
    check("ovf.count", 64'(bus.count_o), 64'd8);
    apply("full.pop_n1", 0, 2'b01, 64'd8, 64'd0, 1);
    check("full.pop_n1.count", 64'(bus.count_o), 64'd8);
    check("full.pop_n1.head", bus.out_order, 64'd1);
    check("full.pop_n1.err", 64'(bus.order_err_o), 64'd0);
    apply("full.pop_n2", 0, 2'b11, 64'd9, 64'd10, 1);
    check("full.pop_n2.count", 64'(bus.count_o), 64'd7);
    check("full.pop_n2.head", bus.out_order, 64'd2);

    // Asynchronous reset away from the clock edge, with entries and a sticky flag present.
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("areset.valid", 64'(bus.out_valid), 64'd0);
    check("areset.count", 64'(bus.count_o), 64'd0);
    check("areset.order", bus.out_order, 64'd0);
    check("areset.pc", 64'(bus.out_pc), 64'd0);
    check("areset.ovf", 64'(bus.overflow_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply("post_reset", 0, 2'b10, 64'd0, 64'd40, 0);
    check("post_reset.order", bus.out_order, 64'd40);

    // Random traffic with alternating congestion phases.
    begin
      logic [63:0] next_ord;
      logic [63:0] o[2];
      logic [1:0]  v;
      logic        rdy;
      int          rdy_pct;
      next_ord = 64'd41;
      for (int c = 0; c < 600; c++) begin
        rdy_pct = ((c / 60) % 2 == 0) ? 80 : 25;
        v = 2'($urandom_range(0, 3));
        for (int k = 0; k < 2; k++) begin
          o[k] = {32'h0, $urandom};
          if (v[k]) begin
            if ($urandom_range(0, 19) == 0) next_ord = next_ord + 64'($urandom_range(1, 3));
            o[k] = next_ord;
            next_ord = next_ord + 64'd1;
          end
        end
        rdy = ($urandom_range(0, 99) < rdy_pct);
        drive(($urandom_range(0, 49) == 0), v, o[0], o[1], $urandom, $urandom, rdy, $urandom);
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
